hdmi_frame_wr_ctrl: RTL and testbench
=====================================

# hdmi_frame_wr_ctrl

Write-side scheduler for the HDMI capture path: watches the 32-bit pixel-word stream that the capture converter pushes into the write FIFO, and issues fixed-length burst write requests to the memory arbiter. Maintains ping-pong frame buffers in external memory and swaps them at each vsync rising edge. Publishes the last completed buffer index to the display reader. Sits between the HDMI capture FIFO and the DDR write-port arbiter, entirely in the `hdmi_clk` domain.

## Interface
- `BURST_LEN`, 64: maximum words per burst, at least 2 and at most 255.
- `FRAME_WORDS`, 786432: words per frame buffer (1024×768).
- `ADDR_W`, 28: word-address width.
- `LVL_W`, 10: width of the FIFO level.
- `BUF0_BASE`, 28'h000_0000: word base address of buffer 0.
- `BUF1_BASE`, 28'h010_0000: word base address of buffer 1.
- `hdmi_clk` in 1: the only clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `hdmi_vs_in` in 1: HDMI vsync. Rising edge marks a frame boundary.
- `fifo_level` in LVL_W: words currently held in the write FIFO.
- `burst_ack` in 1: one-cycle grant from the arbiter.
- `burst_done` in 1: one-cycle pulse when the last beat of the granted burst has been written.
- `burst_req` out 1: burst request.
- `burst_addr` out ADDR_W: start word address of the burst.
- `burst_len` out 8: number of words in the burst.
- `fifo_clr` out 1: one-cycle pulse that clears the write FIFO.
- `wr_buf_idx` out 1: buffer currently being filled.
- `rd_buf_idx` out 1: last fully written buffer.
- `frame_done` out 1: one-cycle pulse on each buffer swap.
- `overflow` out 1: sticky. Set when a frame exceeds FRAME_WORDS.

## Operation
- States:
  - IDLE: waits for the first vsync edge.
  - WAIT: monitors `fifo_level`.
  - REQ: `burst_req` is high, waiting for `burst_ack`.
  - BURST: waiting for `burst_done`.
  - EOF: buffer swap.
- Edge detect: `vs_edge = hdmi_vs_in & ~vs_d1`, where `vs_d1` is a single register.
- IDLE→WAIT on `vs_edge`. Also pulse `fifo_clr` and set `word_off = 0`. The first partial frame is discarded.
- WAIT→REQ when `fifo_level >= BURST_LEN`.
  - `burst_len = min(BURST_LEN, FRAME_WORDS - word_off)`.
  - `burst_addr = base(wr_buf_idx) + word_off`.
- REQ→BURST on `burst_ack`. `burst_ack` is ignored in every other state.
- BURST→WAIT on `burst_done`, with `word_off += burst_len`.
  - If `word_off` now equals FRAME_WORDS, set `full`.
- WAIT with `full` and `fifo_level != 0`: set `overflow`, pulse `fifo_clr`, and issue no further requests this frame.
- `vs_edge` in WAIT→EOF. `vs_edge` in REQ or BURST sets `eof_pend`.
  - After `burst_done`, go to EOF instead of WAIT.
  - A `vs_edge` in the same cycle as `burst_done` behaves the same way.
- EOF (one cycle):
  - `rd_buf_idx <= wr_buf_idx`, `wr_buf_idx <= ~wr_buf_idx`.
  - `word_off <= 0`, `full <= 0`, `eof_pend <= 0`.
  - Pulse `frame_done`, pulse `fifo_clr`.
  - Then go to WAIT.
- Residual words (`0 < fifo_level < BURST_LEN`) at EOF are handled according to Configuration.
- Address arithmetic is unsigned ADDR_W-bit. `word_off` is `$clog2(FRAME_WORDS+1)` bits. `burst_len` never exceeds BURST_LEN and is never 0.

## Timing
- Reset values:
  - `burst_req` = 0, `burst_addr` = 0, `burst_len` = 0.
  - `fifo_clr` = 0, `frame_done` = 0.
  - `wr_buf_idx` = 0, `rd_buf_idx` = 1.
  - `overflow` = 0; state = IDLE.
- Reset asserted mid-burst drops `burst_req` on the next edge. The arbiter shares the same reset.
- All outputs are registered.
- `burst_req` rises one cycle after the level condition is sampled and stays high until the cycle `burst_ack` is sampled, then falls.
- `burst_addr` and `burst_len` are stable from `burst_req` rising until `burst_done`.
- `frame_done` and `fifo_clr` (EOF) are asserted in the same cycle that `wr_buf_idx` changes.
- Pixel data of the next frame arrives no earlier than 4 cycles after `vs_edge`. This is a system guarantee from vertical blanking.

## Configuration
- `HDMI_WR_FLUSH_EN` defined:
  - At a frame boundary with `0 < fifo_level < BURST_LEN` and not `full`, the controller enters FLUSH.
  - FLUSH issues one short burst with `burst_len = min(fifo_level, FRAME_WORDS - word_off)`, using the same REQ/BURST handshake, then proceeds to EOF.
- Not defined: residual words are discarded by the EOF `fifo_clr`, and no FLUSH state is built.

## Structure
- Package `hdmi_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_WAIT`, `ST_REQ`, `ST_BURST`, `ST_FLUSH`, `ST_EOF`);
  - the default BUF0/BUF1 base addresses, shared with the display reader.
- One sub-module: `hdmi_vs_edge_det`, which holds the vsync register and the rising-edge pulse. It is reused by the reader side.

## Test plan
Parameters for the bench: BURST_LEN=4, FRAME_WORDS=10.
- Reset, then one vsync edge → `fifo_clr` pulse, state WAIT, `wr_buf_idx`=0, `rd_buf_idx`=1.
- `fifo_level`=4 → `burst_req` asserted with addr=BUF0_BASE and len=4. Ack, then done → next request at BUF0_BASE+4.
- 10 words written (bursts of 4, 4, then len 2 at off 8), then `fifo_level`=3 → `overflow`=1 and `fifo_clr` pulse.
- Vsync with `fifo_level`=3 and flush enabled → burst of len 3, then EOF: `frame_done`, `wr_buf_idx`=1, `rd_buf_idx`=0. Flush disabled → no burst, immediate EOF.
- Vsync edge in the same cycle as `burst_done` → exactly one EOF, no extra request.
- Reset asserted while in BURST → all outputs at reset values on the next cycle. The next request waits for a new vsync edge.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI capture write path and the display reader.
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_BURST,
    ST_FLUSH,
    ST_EOF
  } wr_state_e;

  localparam logic [27:0] BUF0_BASE_DEF = 28'h000_0000;
  localparam logic [27:0] BUF1_BASE_DEF = 28'h010_0000;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_frame_wr_ctrl_if.sv
// Burst-request and write-FIFO handshake between the frame write controller and its neighbours.
interface hdmi_frame_wr_ctrl_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LVL_W  = 10
);
  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  logic [7:0]        burst_len;
  logic              burst_ack;
  logic              burst_done;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_clr;

  modport master (
    output burst_req, burst_addr, burst_len, fifo_clr,
    input  burst_ack, burst_done, fifo_level
  );

  modport slave (
    input  burst_req, burst_addr, burst_len, fifo_clr,
    output burst_ack, burst_done, fifo_level
  );
endinterface

// File: rtl/hdmi_vs_edge_det.sv
// Vsync rising-edge detector: one history register, combinational single-cycle pulse.
module hdmi_vs_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vs_i,
  output logic vs_edge_o
);
  logic vs_d1_q, vs_d1_d;

  assign vs_d1_d = vs_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) vs_d1_q <= 1'b0;
    else         vs_d1_q <= vs_d1_d;
  end

  assign vs_edge_o = vs_i & ~vs_d1_q;
endmodule

// File: rtl/hdmi_frame_wr_ctrl.sv
// Ping-pong frame write scheduler: issues fixed-length DDR bursts from the capture FIFO.
// Define HDMI_WR_FLUSH_EN to write out residual FIFO words as a short burst at each frame end.
module hdmi_frame_wr_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned       BURST_LEN   = 64,
  parameter int unsigned       FRAME_WORDS = 786432,
  parameter int unsigned       ADDR_W      = 28,
  parameter int unsigned       LVL_W       = 10,
  parameter logic [ADDR_W-1:0] BUF0_BASE   = ADDR_W'(BUF0_BASE_DEF),
  parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(BUF1_BASE_DEF)
) (
  input  logic                  hdmi_clk,
  input  logic                  sys_rst_n,
  input  logic                  hdmi_vs_in,
  hdmi_frame_wr_ctrl_if.master  bus,
  output logic                  wr_buf_idx,
  output logic                  rd_buf_idx,
  output logic                  frame_done,
  output logic                  overflow
);
  localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);
  localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);
`ifdef HDMI_WR_FLUSH_EN
  localparam wr_state_e ST_BOUNDARY = ST_FLUSH;
`else
  localparam wr_state_e ST_BOUNDARY = ST_EOF;
`endif

  wr_state_e         state_q, state_d;
  logic [OFF_W-1:0]  word_off_q, word_off_d;
  logic              full_q, full_d, eof_pend_q, eof_pend_d, flush_q, flush_d;
  logic              burst_req_q, burst_req_d;
  logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
  logic [7:0]        burst_len_q, burst_len_d;
  logic              fifo_clr_q, fifo_clr_d, frame_done_q, frame_done_d;
  logic              wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, overflow_q, overflow_d;
  logic              vs_edge;
  logic [OFF_W-1:0]  remain;
  logic [7:0]        full_len;
  logic [ADDR_W-1:0] cur_addr;

  hdmi_vs_edge_det u_vs_edge (
    .clk_i     (hdmi_clk),
    .rst_ni    (sys_rst_n),
    .vs_i      (hdmi_vs_in),
    .vs_edge_o (vs_edge)
  );

  assign remain   = FRAME_OFF - word_off_q;
  assign full_len = 8'(min_u(32'(remain), BURST_LEN));
  assign cur_addr = (wr_buf_q ? BUF1_BASE : BUF0_BASE) + ADDR_W'(word_off_q);

  always_comb begin
    state_d      = state_q;
    word_off_d   = word_off_q;
    full_d       = full_q;
    eof_pend_d   = eof_pend_q;
    flush_d      = flush_q;
    burst_req_d  = burst_req_q;
    burst_addr_d = burst_addr_q;
    burst_len_d  = burst_len_q;
    fifo_clr_d   = 1'b0;
    frame_done_d = 1'b0;
    wr_buf_d     = wr_buf_q;
    rd_buf_d     = rd_buf_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        // Discard the partial frame captured before the first boundary.
        if (vs_edge) begin
          state_d    = ST_WAIT;
          fifo_clr_d = 1'b1;
          word_off_d = '0;
          full_d     = 1'b0;
          eof_pend_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (vs_edge) begin
          state_d = ST_BOUNDARY;
        end else if (full_q) begin
          // Alternate with the previous clear so the FIFO sees single-cycle pulses.
          if (bus.fifo_level != '0 && !fifo_clr_q) begin
            overflow_d = 1'b1;
            fifo_clr_d = 1'b1;
          end
        end else if (32'(bus.fifo_level) >= BURST_LEN) begin
          state_d      = ST_REQ;
          burst_req_d  = 1'b1;
          burst_addr_d = cur_addr;
          burst_len_d  = full_len;
        end
      end
      ST_REQ: begin
        if (vs_edge) eof_pend_d = 1'b1;
        if (bus.burst_ack) begin
          state_d     = ST_BURST;
          burst_req_d = 1'b0;
        end
      end
      ST_BURST: begin
        if (vs_edge) eof_pend_d = 1'b1;
        if (bus.burst_done) begin
          word_off_d = word_off_q + OFF_W'(burst_len_q);
          full_d     = (word_off_d == FRAME_OFF);
          if (flush_q)                      state_d = ST_EOF;
          else if (eof_pend_q || vs_edge)   state_d = ST_BOUNDARY;
          else                              state_d = ST_WAIT;
        end
      end
      ST_FLUSH: begin
`ifdef HDMI_WR_FLUSH_EN
        if (bus.fifo_level != '0 && 32'(bus.fifo_level) < BURST_LEN && !full_q) begin
          state_d      = ST_REQ;
          flush_d      = 1'b1;
          burst_req_d  = 1'b1;
          burst_addr_d = cur_addr;
          burst_len_d  = 8'(min_u(32'(bus.fifo_level), 32'(remain)));
        end else begin
          state_d = ST_EOF;
        end
`else
        state_d = ST_EOF;
`endif
      end
      ST_EOF: begin
        rd_buf_d     = wr_buf_q;
        wr_buf_d     = ~wr_buf_q;
        word_off_d   = '0;
        full_d       = 1'b0;
        eof_pend_d   = 1'b0;
        flush_d      = 1'b0;
        frame_done_d = 1'b1;
        fifo_clr_d   = 1'b1;
        state_d      = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hdmi_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      word_off_q   <= '0;
      full_q       <= 1'b0;
      eof_pend_q   <= 1'b0;
      flush_q      <= 1'b0;
      burst_req_q  <= 1'b0;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
      fifo_clr_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_off_q   <= word_off_d;
      full_q       <= full_d;
      eof_pend_q   <= eof_pend_d;
      flush_q      <= flush_d;
      burst_req_q  <= burst_req_d;
      burst_addr_q <= burst_addr_d;
      burst_len_q  <= burst_len_d;
      fifo_clr_q   <= fifo_clr_d;
      frame_done_q <= frame_done_d;
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.burst_req  = burst_req_q;
  assign bus.burst_addr = burst_addr_q;
  assign bus.burst_len  = burst_len_q;
  assign bus.fifo_clr   = fifo_clr_q;
  assign wr_buf_idx     = wr_buf_q;
  assign rd_buf_idx     = rd_buf_q;
  assign frame_done     = frame_done_q;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_hdmi_frame_wr_ctrl.sv
// Directed bench for hdmi_frame_wr_ctrl with BURST_LEN=4, FRAME_WORDS=10.
module tb_hdmi_frame_wr_ctrl;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LVL_W  = 10;
  localparam logic [27:0] B0 = 28'h000_0000;
  localparam logic [27:0] B1 = 28'h010_0000;

  typedef struct packed {
    logic        req;
    logic [27:0] addr;
    logic [7:0]  len;
    logic        clr;
    logic        fd;
    logic        wr;
    logic        rd;
    logic        ovf;
  } outs_t;

  typedef struct {
    logic       vs;
    logic [9:0] lvl;
    logic       ack;
    logic       done;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic wr_idx, rd_idx, fd, ovf;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hdmi_frame_wr_ctrl_if #(.ADDR_W(ADDR_W), .LVL_W(LVL_W)) bus ();

  hdmi_frame_wr_ctrl #(
    .BURST_LEN   (4),
    .FRAME_WORDS (10),
    .ADDR_W      (ADDR_W),
    .LVL_W       (LVL_W)
  ) dut (
    .hdmi_clk   (clk),
    .sys_rst_n  (rst_n),
    .hdmi_vs_in (vs),
    .bus        (bus),
    .wr_buf_idx (wr_idx),
    .rd_buf_idx (rd_idx),
    .frame_done (fd),
    .overflow   (ovf)
  );

  function automatic outs_t mk(input logic req, input logic [27:0] addr, input logic [7:0] len,
                               input logic clr, input logic f, input logic wr, input logic rd,
                               input logic ov);
    outs_t o;
    o.req = req; o.addr = addr; o.len = len; o.clr = clr;
    o.fd = f; o.wr = wr; o.rd = rd; o.ovf = ov;
    return o;
  endfunction

  function automatic vec_t mv(input logic v, input logic [9:0] l, input logic a, input logic d,
                              input outs_t e);
    vec_t r;
    r.vs = v; r.lvl = l; r.ack = a; r.done = d; r.exp = e;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = {bus.burst_req, bus.burst_addr, bus.burst_len, bus.fifo_clr, fd, wr_idx, rd_idx, ovf};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h len=%0d clr=%0b fd=%0b wr=%0b rd=%0b ovf=%0b, expected req=%0b addr=%h len=%0d clr=%0b fd=%0b wr=%0b rd=%0b ovf=%0b",
               name, got.req, got.addr, got.len, got.clr, got.fd, got.wr, got.rd, got.ovf,
               exp.req, exp.addr, exp.len, exp.clr, exp.fd, exp.wr, exp.rd, exp.ovf);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Runs n cycles counting frame_done and burst_req; captures {fifo_clr, wr, rd} at frame_done.
  task automatic watch(input int n, output int fds, output int reqs, output logic [2:0] at_fd);
    fds = 0; reqs = 0; at_fd = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.burst_req) reqs++;
      if (fd) begin
        fds++;
        at_fd = {bus.fifo_clr, wr_idx, rd_idx};
      end
    end
  endtask

  task automatic wait_req(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n && seen == 0; i++) begin
      step();
      if (bus.burst_req) seen = 1;
    end
  endtask

  vec_t       vecs[15];
  int         fds, reqs, seen;
  logic [2:0] at_fd;

  initial begin
    vecs[0]  = mv(1, 0, 0, 0, mk(0, B0,     0, 1, 0, 0, 1, 0));
    vecs[1]  = mv(1, 0, 0, 0, mk(0, B0,     0, 0, 0, 0, 1, 0));
    vecs[2]  = mv(0, 4, 0, 0, mk(1, B0,     4, 0, 0, 0, 1, 0));
    vecs[3]  = mv(0, 4, 0, 0, mk(1, B0,     4, 0, 0, 0, 1, 0));
    vecs[4]  = mv(0, 4, 1, 0, mk(0, B0,     4, 0, 0, 0, 1, 0));
    vecs[5]  = mv(0, 0, 0, 1, mk(0, B0,     4, 0, 0, 0, 1, 0));
    vecs[6]  = mv(0, 0, 1, 1, mk(0, B0,     4, 0, 0, 0, 1, 0));
    vecs[7]  = mv(0, 4, 0, 0, mk(1, B0 + 4, 4, 0, 0, 0, 1, 0));
    vecs[8]  = mv(0, 4, 1, 0, mk(0, B0 + 4, 4, 0, 0, 0, 1, 0));
    vecs[9]  = mv(0, 0, 0, 1, mk(0, B0 + 4, 4, 0, 0, 0, 1, 0));
    vecs[10] = mv(0, 4, 0, 0, mk(1, B0 + 8, 2, 0, 0, 0, 1, 0));
    vecs[11] = mv(0, 4, 1, 0, mk(0, B0 + 8, 2, 0, 0, 0, 1, 0));
    vecs[12] = mv(0, 0, 0, 1, mk(0, B0 + 8, 2, 0, 0, 0, 1, 0));
    vecs[13] = mv(0, 3, 0, 0, mk(0, B0 + 8, 2, 1, 0, 0, 1, 1));
    vecs[14] = mv(0, 0, 0, 0, mk(0, B0 + 8, 2, 0, 0, 0, 1, 1));

    bus.fifo_level = '0;
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b0;

    repeat (2) step();
    check("reset", mk(0, 0, 0, 0, 0, 0, 1, 0));
    rst_n = 1'b1;
    step();
    check("idle", mk(0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < 15; i++) begin
      vs             = vecs[i].vs;
      bus.fifo_level = vecs[i].lvl;
      bus.burst_ack  = vecs[i].ack;
      bus.burst_done = vecs[i].done;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b0;

    // Frame boundary after a full, overflowed frame: no flush burst, one swap.
    vs = 1'b1;
    watch(6, fds, reqs, at_fd);
    check_val("eof1_fd_count", fds, 1);
    check_val("eof1_req_count", reqs, 0);
    check_val("eof1_clr_wr_rd", int'(at_fd), 3'b110);
    check_val("ovf_sticky", int'(ovf), 1);

    // Residual words at the next boundary.
    vs = 1'b0;
    bus.fifo_level = 10'd3;
    step();
    step();
    check_val("resid_no_req", int'(bus.burst_req), 0);
    vs = 1'b1;
`ifdef HDMI_WR_FLUSH_EN
    wait_req(5, seen);
    check_val("flush_req_seen", seen, 1);
    check_val("flush_addr", int'(bus.burst_addr), int'(B1));
    check_val("flush_len", int'(bus.burst_len), 3);
    bus.burst_ack  = 1'b1;
    bus.fifo_level = '0;
    step();
    bus.burst_ack = 1'b0;
    check_val("flush_req_drop", int'(bus.burst_req), 0);
    bus.burst_done = 1'b1;
    step();
    bus.burst_done = 1'b0;
    watch(4, fds, reqs, at_fd);
`else
    watch(6, fds, reqs, at_fd);
    check_val("noflush_req_count", reqs, 0);
    bus.fifo_level = '0;
`endif
    check_val("eof2_fd_count", fds, 1);
    check_val("eof2_clr_wr_rd", int'(at_fd), 3'b101);

    // vsync edge coincident with burst_done.
    vs = 1'b0;
    bus.fifo_level = 10'd4;
    wait_req(4, seen);
    check_val("coinc_req_seen", seen, 1);
    check_val("coinc_addr", int'(bus.burst_addr), int'(B0));
    check_val("coinc_len", int'(bus.burst_len), 4);
    bus.burst_ack  = 1'b1;
    bus.fifo_level = '0;
    step();
    bus.burst_ack  = 1'b0;
    bus.burst_done = 1'b1;
    vs = 1'b1;
    step();
    bus.burst_done = 1'b0;
    watch(7, fds, reqs, at_fd);
    check_val("coinc_fd_count", fds, 1);
    check_val("coinc_req_count", reqs, 0);
    check_val("coinc_clr_wr_rd", int'(at_fd), 3'b110);

    // Reset while a burst is outstanding.
    vs = 1'b0;
    bus.fifo_level = 10'd4;
    wait_req(4, seen);
    check_val("rstb_req_seen", seen, 1);
    check_val("rstb_addr", int'(bus.burst_addr), int'(B1));
    bus.burst_ack  = 1'b1;
    bus.fifo_level = '0;
    step();
    bus.burst_ack = 1'b0;
    check_val("rstb_in_burst", int'(bus.burst_req), 0);
    rst_n = 1'b0;
    step();
    check("rst_mid_burst", mk(0, 0, 0, 0, 0, 0, 1, 0));
    rst_n = 1'b1;
    bus.fifo_level = 10'd4;
    watch(6, fds, reqs, at_fd);
    check_val("post_rst_req_count", reqs, 0);
    vs = 1'b1;
    step();
    check("restart_vs", mk(0, 0, 0, 1, 0, 0, 1, 0));
    step();
    check("restart_req", mk(1, B0, 4, 0, 0, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
